cv32e40x_mult_iter: RTL

//  Parametrised iterative multiplier for the EX stage; successor to the fixed 16-bit-slice MULH unit.

---
 rtl/cv32e40x_pkg.sv | 15 +
 rtl/cv32e40x_mult_iter_mac.sv | 22 ++
 rtl/cv32e40x_mult_iter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared EX-stage types: multiplier opcodes and the iterative multiplier's FSM states.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    MUL_M32 = 2'b00,
    MUL_H   = 2'b01
  } mul_opcode_e;

  typedef enum logic [1:0] {
    MI_IDLE,
    MI_CALC,
    MI_DONE
  } mult_iter_state_e;

endpackage

// File: rtl/cv32e40x_mult_iter_mac.sv
// One radix-2^SLICE_W step: signed (XLEN+1)x(SLICE_W+1) multiply plus the running high accumulator.
module cv32e40x_mult_iter_mac #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic [XLEN:0]           acc_hi_i,
  input  logic [XLEN:0]           op_a_i,
  input  logic [SLICE_W:0]        slice_i,
  output logic [XLEN+SLICE_W:0]   sum_o
);

  localparam int unsigned SumW = XLEN + SLICE_W + 1;

  // Truncation to SumW is safe: only bits below SumW feed the next accumulator and lo shift.
  logic signed [SumW-1:0] a_x, s_x, acc_x;

  assign a_x   = SumW'($signed(op_a_i));
  assign s_x   = SumW'($signed(slice_i));
  assign acc_x = SumW'($signed(acc_hi_i));
  assign sum_o = a_x * s_x + acc_x;

endmodule

// File: rtl/cv32e40x_mult_iter.sv
// Iterative MUL/MULH unit: consumes op_b SLICE_W bits per cycle, with an optional one-cycle MUL path.
module cv32e40x_mult_iter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SLICE_W  = 8,
  parameter bit          FAST_MUL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  mul_opcode_e       operator_i,
  input  logic [1:0]        signed_mode_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [XLEN-1:0]   result_o,
  output logic              ready_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int unsigned N    = XLEN / SLICE_W;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SumW = XLEN + SLICE_W + 1;

  if ((XLEN % SLICE_W) != 0) begin : g_bad_slice
    $error("SLICE_W must divide XLEN");
  end

  mult_iter_state_e  state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, lo_q, lo_d;
  logic [XLEN:0]     acc_q, acc_d;
  mul_opcode_e       op_q, op_d;
  logic [1:0]        sm_q, sm_d;

  logic [XLEN:0]     a_ext;
  logic [XLEN-1:0]   b_sh;
  logic [SLICE_W:0]  slice;
  logic              last;
  logic [SumW-1:0]   sum;
  logic [2*XLEN-1:0] lo_cat;
  logic [XLEN-1:0]   fast_res;
  logic              fast_en;

  assign a_ext  = {sm_q[0] & a_q[XLEN-1], a_q};
  assign b_sh   = b_q >> (32'(cnt_q) * SLICE_W);
  assign last   = (cnt_q == CntW'(N - 1));
  // Only the top slice carries op_b's extension bit as a sign; lower slices are unsigned.
  assign slice  = {last & sm_q[1] & b_q[XLEN-1], b_sh[SLICE_W-1:0]};
  assign lo_cat = {XLEN'(sum[SLICE_W-1:0]), lo_q};

  cv32e40x_mult_iter_mac #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W)
  ) i_mac (
    .acc_hi_i (acc_q),
    .op_a_i   (a_ext),
    .slice_i  (slice),
    .sum_o    (sum)
  );

  if (FAST_MUL) begin : g_fast
    assign fast_res = op_a_i * op_b_i;
  end else begin : g_no_fast
    assign fast_res = '0;
  end
  assign fast_en = FAST_MUL & (operator_i == MUL_M32);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sm_d     = sm_q;
    valid_o  = 1'b0;
    ready_o  = 1'b0;
    result_o = '0;
    unique case (state_q)
      MI_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (fast_en) begin
            valid_o  = 1'b1;
            ready_o  = ready_i;
            result_o = fast_res;
          end else begin
            ready_o = 1'b0;
            a_d     = op_a_i;
            b_d     = op_b_i;
            op_d    = operator_i;
            sm_d    = signed_mode_i;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = '0;
            state_d = MI_CALC;
          end
        end
      end
      MI_CALC: begin
        acc_d = sum[SLICE_W +: XLEN+1];
        lo_d  = lo_cat[SLICE_W +: XLEN];
        if (last) begin
          state_d = MI_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MI_DONE: begin
        valid_o  = 1'b1;
        result_o = (op_q == MUL_H) ? acc_q[XLEN-1:0] : lo_q;
        if (ready_i) begin
          ready_o = 1'b1;
          acc_d   = '0;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = MI_IDLE;
        end
      end
      default: state_d = MI_IDLE;
    endcase
    // Kill wins over everything, including a concurrent downstream accept.
    if (!valid_i) begin
      state_d  = MI_IDLE;
      acc_d    = '0;
      lo_d     = '0;
      cnt_d    = '0;
      valid_o  = 1'b0;
      ready_o  = 1'b1;
      result_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MI_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MUL_M32;
      sm_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sm_q    <= sm_d;
    end
  end

endmodule
